// File: rtl/ex_stage.sv
// Execute stage: registers the decode bus, runs the single-cycle ALU, drives the data SRAM,
// forwards to decode, and runs a 32-cycle restoring divider for DIV/DIVU.
module ex_stage #(
  parameter int StallBus = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [StallBus-1:0] stall,
  input  logic [158:0]        id_to_ex_bus,
  output logic                stallreq,
  output logic [37:0]         ex_to_id_bus,
  output logic [141:0]        ex_to_mem_bus,
  output logic                data_sram_en,
  output logic [3:0]          data_sram_wen,
  output logic [31:0]         data_sram_addr,
  output logic [31:0]         data_sram_wdata
);

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [11:0] alu_op;
    logic [2:0]  sel_alu_src1;
    logic [3:0]  sel_alu_src2;
    logic        data_ram_en;
    logic [3:0]  data_ram_wen;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic        sel_rf_res;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
  } id_ex_t;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  id_ex_t ex_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                      ex_r <= '0;
    else if (stall[2] == Stop && stall[3] == NoStop) ex_r <= '0;
    else if (stall[2] == NoStop)                  ex_r <= id_to_ex_bus;
  end

  // ALU
  logic [31:0] src1, src2, alu_res, sra_res, imm_sext, imm_zext;
  logic [4:0]  shamt;

  assign imm_sext = {{16{ex_r.inst[15]}}, ex_r.inst[15:0]};
  assign imm_zext = {16'b0, ex_r.inst[15:0]};

  assign src1 = ({32{ex_r.sel_alu_src1[0]}} & ex_r.rdata1)
              | ({32{ex_r.sel_alu_src1[1]}} & ex_r.pc)
              | ({32{ex_r.sel_alu_src1[2]}} & {27'b0, ex_r.inst[10:6]});

  assign src2 = ({32{ex_r.sel_alu_src2[0]}} & ex_r.rdata2)
              | ({32{ex_r.sel_alu_src2[1]}} & imm_sext)
              | ({32{ex_r.sel_alu_src2[2]}} & 32'd8)
              | ({32{ex_r.sel_alu_src2[3]}} & imm_zext);

  assign shamt   = src1[4:0];
  assign sra_res = $signed(src2) >>> shamt;

  assign alu_res = ({32{ex_r.alu_op[11]}} & (src1 + src2))
                 | ({32{ex_r.alu_op[10]}} & (src1 - src2))
                 | ({32{ex_r.alu_op[9]}}  & {31'b0, $signed(src1) < $signed(src2)})
                 | ({32{ex_r.alu_op[8]}}  & {31'b0, src1 < src2})
                 | ({32{ex_r.alu_op[7]}}  & (src1 & src2))
                 | ({32{ex_r.alu_op[6]}}  & ~(src1 | src2))
                 | ({32{ex_r.alu_op[5]}}  & (src1 | src2))
                 | ({32{ex_r.alu_op[4]}}  & (src1 ^ src2))
                 | ({32{ex_r.alu_op[3]}}  & (src2 << shamt))
                 | ({32{ex_r.alu_op[2]}}  & (src2 >> shamt))
                 | ({32{ex_r.alu_op[1]}}  & sra_res)
                 | ({32{ex_r.alu_op[0]}}  & {src2[15:0], 16'b0});

  // Divider
  state_t      state, state_nxt;
  logic [4:0]  cnt;
  logic [63:0] rem, rem_step;
  logic [32:0] diff;
  logic [31:0] divisor, dividend, a_mag, b_mag, quo, rmd, hi_res, lo_res, hi, lo;
  logic        is_div, div_signed, neg_q, neg_r, div0, hilo_we;

  assign is_div     = (ex_r.inst[31:26] == 6'd0) &&
                      (ex_r.inst[5:0] == 6'h1A || ex_r.inst[5:0] == 6'h1B);
  assign div_signed = ~ex_r.inst[0];
  assign a_mag      = (div_signed && ex_r.rdata1[31]) ? -ex_r.rdata1 : ex_r.rdata1;
  assign b_mag      = (div_signed && ex_r.rdata2[31]) ? -ex_r.rdata2 : ex_r.rdata2;

  // 33-bit trial subtract: the shifted partial remainder can exceed 32 bits
  assign diff     = rem[63:31] - {1'b0, divisor};
  assign rem_step = diff[32] ? {rem[62:0], 1'b0} : {diff[31:0], rem[30:0], 1'b1};

  always_comb begin
    state_nxt = state;
    stallreq  = 1'b0;
    hilo_we   = 1'b0;
    case (state)
      IDLE: if (is_div) begin
        stallreq  = 1'b1;
        state_nxt = BUSY;
      end
      BUSY: begin
        stallreq = 1'b1;
        if (cnt == 5'd31) state_nxt = DONE;
      end
      DONE: begin
        hilo_we = 1'b1;
        if (stall[2] == NoStop) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      rem      <= '0;
      divisor  <= '0;
      dividend <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div0     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && is_div) begin
        rem      <= {32'b0, a_mag};
        divisor  <= b_mag;
        dividend <= ex_r.rdata1;
        neg_q    <= div_signed & (ex_r.rdata1[31] ^ ex_r.rdata2[31]);
        neg_r    <= div_signed & ex_r.rdata1[31];
        div0     <= (ex_r.rdata2 == 32'd0);
        cnt      <= '0;
      end else if (state == BUSY) begin
        rem <= rem_step;
        cnt <= cnt + 5'd1;
      end
    end
  end

  assign quo    = rem[31:0];
  assign rmd    = rem[63:32];
  assign lo_res = div0 ? 32'hFFFF_FFFF : (neg_q ? -quo : quo);
  assign hi_res = div0 ? dividend      : (neg_r ? -rmd : rmd);
  assign hi     = hilo_we ? hi_res : 32'd0;
  assign lo     = hilo_we ? lo_res : 32'd0;

  // Outputs; the named fields total 141 bits, so the bus MSB is a constant zero
  assign data_sram_en    = ex_r.data_ram_en;
  assign data_sram_wen   = ex_r.data_ram_wen;
  assign data_sram_addr  = alu_res;
  assign data_sram_wdata = ex_r.rdata2;

  assign ex_to_id_bus  = {ex_r.rf_we & ~ex_r.sel_rf_res, ex_r.rf_waddr, alu_res};
  assign ex_to_mem_bus = {1'b0, ex_r.pc, ex_r.data_ram_en, ex_r.data_ram_wen, ex_r.sel_rf_res,
                          ex_r.rf_we, ex_r.rf_waddr, alu_res, hilo_we, hi, lo};

  logic unused;
  assign unused = ^{stall[StallBus-1:4], stall[1:0], ex_r.inst[25:16]};

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed ALU table, directed divider sequences,
// and randomized traffic against a behavioural reference model.
module tb_ex_stage;
  logic         clk = 1'b0;
  logic         rst;
  logic [5:0]   stall;
  logic [158:0] id;
  logic         stallreq;
  logic [37:0]  e2id;
  logic [141:0] e2m;
  logic         sen;
  logic [3:0]   swen;
  logic [31:0]  saddr, swdata;

  logic       hold_mem = 1'b0;
  logic       force_en = 1'b0;
  logic [5:0] force_val = 6'b0;
  int checks = 0;
  int errors = 0;

  localparam logic [11:0] ADD = 12'h800, SUB = 12'h400, SLT = 12'h200, SLTU = 12'h100;
  localparam logic [11:0] OR  = 12'h020, SRA = 12'h002, LUI = 12'h001;

  always #5 clk = ~clk;

  // Behaves like the stall controller: EX stall requests hold IF..MEM
  assign stall = force_en ? force_val : ((stallreq | hold_mem) ? 6'b001111 : 6'b000000);

  ex_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .id_to_ex_bus(id), .stallreq(stallreq),
    .ex_to_id_bus(e2id), .ex_to_mem_bus(e2m), .data_sram_en(sen), .data_sram_wen(swen),
    .data_sram_addr(saddr), .data_sram_wdata(swdata)
  );

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [158:0] mk(input logic [31:0] pc, input logic [31:0] inst,
      input logic [11:0] op, input logic [2:0] s1, input logic [3:0] s2, input logic en,
      input logic [3:0] wen, input logic we, input logic [4:0] wa, input logic selres,
      input logic [31:0] r1, input logic [31:0] r2);
    return {pc, inst, op, s1, s2, en, wen, we, wa, selres, r1, r2};
  endfunction

  function automatic logic [158:0] divbus(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] inst;
    inst = {6'b0, 5'd4, 5'd5, 10'b0, (sgn ? 6'h1A : 6'h1B)};
    return mk(32'hBFC0_0200, inst, 12'h0, 3'b0, 4'b0, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0, a, b);
  endfunction

  // Reference ALU indexed by alu_op bit position and select index
  function automatic logic [31:0] ref_alu(input int op, input int s1, input int s2,
      input logic [31:0] pc, input logic [31:0] inst, input logic [31:0] r1, input logic [31:0] r2);
    logic [31:0] a, b, r;
    logic signed [31:0] bs;
    case (s1)
      0: a = r1;
      1: a = pc;
      2: a = {27'b0, inst[10:6]};
      default: a = 32'd0;
    endcase
    case (s2)
      0: b = r2;
      1: b = {{16{inst[15]}}, inst[15:0]};
      2: b = 32'd8;
      3: b = {16'b0, inst[15:0]};
      default: b = 32'd0;
    endcase
    bs = b;
    case (op)
      11: r = a + b;
      10: r = a - b;
      9:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      8:  r = (a < b) ? 32'd1 : 32'd0;
      7:  r = a & b;
      6:  r = ~(a | b);
      5:  r = a | b;
      4:  r = a ^ b;
      3:  r = b << a[4:0];
      2:  r = b >> a[4:0];
      1:  r = $unsigned(bs >>> a[4:0]);
      0:  r = {b[15:0], 16'h0};
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // Reference divide: returns {hi, lo}
  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint x, y, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sgn) begin
      x = $signed(a);
      y = $signed(b);
    end else begin
      x = {32'b0, a};
      y = {32'b0, b};
    end
    q = x / y;
    r = x % y;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic load(input logic [158:0] b);
    @(negedge clk);
    id = b;
    @(posedge clk);
    #1;
  endtask

  // Runs one divide from its cycle 0 through cycle 33 (plus optional downstream hold).
  // With pre=1 the divide is already in EX and the current time is cycle 0.
  task automatic run_div(input string nm, input logic [158:0] b, input logic [31:0] ehi,
      input logic [31:0] elo, input int hold, input logic [158:0] nxt, input bit pre);
    int hi_cnt;
    if (!pre) load(b);
    id = nxt;
    hi_cnt = 0;
    for (int k = 0; k <= 32; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      if (stallreq) hi_cnt++;
    end
    @(posedge clk);
    #1;
    chk({nm, ".stallreq_cycles"}, 160'(hi_cnt), 160'd33);
    chk({nm, ".done"}, {stallreq, e2m[64], e2m[63:0]}, {1'b0, 1'b1, ehi, elo});
    if (hold > 0) begin
      hold_mem = 1'b1;
      for (int h = 0; h < hold; h++) begin
        @(posedge clk);
        #1;
        chk({nm, ".hold"}, {stallreq, e2m[64], e2m[63:0]}, {1'b0, 1'b1, ehi, elo});
      end
      hold_mem = 1'b0;
    end
  endtask

  typedef struct {
    string        nm;
    logic [158:0] bus;
    logic [31:0]  res;
    logic         fwd_we;
  } vec_t;

  vec_t vt[10];
  logic [31:0]  pc, inst, r1, r2, res, da, db;
  logic [11:0]  op;
  logic [2:0]   s1;
  logic [3:0]   s2, wen;
  logic [4:0]   wa;
  logic         en, we, selres, sgn;
  int           opi, s1i, s2i;
  logic [63:0]  dv;

  initial begin
    rst = 1'b1;
    id  = '0;
    vt[0] = '{"ori",   mk(32'h400, 32'h3509_0034, OR,   3'b001, 4'b1000, 1'b0, 4'h0, 1'b1, 5'd9,  1'b0, 32'h0000_1200, 32'hDEAD_BEEF), 32'h0000_1234, 1'b1};
    vt[1] = '{"sra",   mk(32'h404, 32'h0000_0103, SRA,  3'b100, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd3,  1'b0, 32'h0,         32'h8000_0000), 32'hF800_0000, 1'b1};
    vt[2] = '{"slt",   mk(32'h408, 32'h0000_002A, SLT,  3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd4,  1'b0, 32'hFFFF_FFFF, 32'h1),         32'd1,         1'b1};
    vt[3] = '{"sltu",  mk(32'h40C, 32'h0000_002B, SLTU, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd4,  1'b0, 32'hFFFF_FFFF, 32'h1),         32'd0,         1'b1};
    vt[4] = '{"store", mk(32'h410, 32'hAC00_FFFC, ADD,  3'b001, 4'b0010, 1'b1, 4'hF, 1'b0, 5'd0,  1'b0, 32'h0000_1000, 32'hCAFE_BABE), 32'h0000_0FFC, 1'b0};
    vt[5] = '{"load",  mk(32'h414, 32'h8C00_0010, ADD,  3'b001, 4'b0010, 1'b1, 4'h0, 1'b1, 5'd7,  1'b1, 32'h0000_2000, 32'h0),         32'h0000_2010, 1'b0};
    vt[6] = '{"lui",   mk(32'h418, 32'h3C00_ABCD, LUI,  3'b000, 4'b1000, 1'b0, 4'h0, 1'b1, 5'd5,  1'b0, 32'h0,         32'h0),         32'hABCD_0000, 1'b1};
    vt[7] = '{"link",  mk(32'hBFC0_0100, 32'h0C00_0000, ADD, 3'b010, 4'b0100, 1'b0, 4'h0, 1'b1, 5'd31, 1'b0, 32'h0,    32'h0),         32'hBFC0_0108, 1'b1};
    vt[8] = '{"noop",  mk(32'h420, 32'h0000_0000, 12'h0, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd2,  1'b0, 32'd5,         32'd6),         32'd0,         1'b1};
    vt[9] = '{"sub",   mk(32'h424, 32'h0000_0023, SUB,  3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd8,  1'b0, 32'd10,        32'd20),        32'hFFFF_FFF6, 1'b1};

    repeat (2) @(posedge clk);
    #1;
    chk("reset.mem", 160'(e2m), 160'd0);
    chk("reset.id_sram", {stallreq, e2id, sen, swen, saddr, swdata}, 160'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      load(vt[i].bus);
      chk({vt[i].nm, ".rf_wdata"}, 160'(e2m[96:65]), 160'(vt[i].res));
      chk({vt[i].nm, ".fwd"}, 160'(e2id), 160'({vt[i].fwd_we, vt[i].bus[69:65], vt[i].res}));
      chk({vt[i].nm, ".sram"}, {sen, swen, saddr, swdata},
          160'({vt[i].bus[75], vt[i].bus[74:71], vt[i].res, vt[i].bus[31:0]}));
      chk({vt[i].nm, ".nodiv"}, {stallreq, e2m[64]}, 160'd0);
    end

    // Bubble, then EX hold
    load(vt[4].bus);
    force_en = 1'b1; force_val = 6'b000111;
    @(posedge clk); #1;
    chk("bubble", {e2m, e2id, sen, swen, stallreq}, 160'd0);
    force_en = 1'b0;
    load(vt[1].bus);
    force_en = 1'b1; force_val = 6'b001111; id = vt[2].bus;
    @(posedge clk); #1;
    chk("ex_hold", 160'(e2m[96:65]), 160'h0000_0000_F800_0000);
    force_en = 1'b0;

    run_div("div_s", divbus(1'b1, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, '0, 1'b0);
    run_div("divu", divbus(1'b0, 32'hFFFF_FFFF, 32'd16), 32'd15, 32'h0FFF_FFFF, 3, '0, 1'b0);
    @(posedge clk); #1;
    chk("no_restart", {stallreq, e2m[64]}, 160'd0);

    run_div("div0", divbus(1'b1, 32'd5, 32'd0), 32'd5, 32'hFFFF_FFFF, 0, divbus(1'b0, 32'd100, 32'd7), 1'b0);
    @(posedge clk); #1;
    chk("b2b.start", 160'(stallreq), 160'd1);
    run_div("b2b", '0, 32'd2, 32'd14, 0, '0, 1'b1);

    // Reset in the middle of a divide
    load(divbus(1'b0, 32'd1000, 32'd3));
    id = '0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_mid.stallreq", 160'(stallreq), 160'd0);
    chk("rst_mid.mem", 160'(e2m), 160'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid.idle", {stallreq, e2m[64]}, 160'd0);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 15) == 0) begin
        sgn = 1'($urandom_range(0, 1));
        da  = $urandom;
        case ($urandom_range(0, 3))
          0: db = 32'd0;
          1: db = $urandom_range(1, 20);
          2: db = -$urandom_range(1, 20);
          default: db = $urandom;
        endcase
        dv = ref_div(sgn, da, db);
        run_div("rand_div", divbus(sgn, da, db), dv[63:32], dv[31:0], 0, '0, 1'b0);
      end else begin
        pc = $urandom; inst = $urandom; r1 = $urandom; r2 = $urandom;
        if (inst[31:26] == 6'd0 && inst[5:1] == 5'b01101) inst[31] = 1'b1;
        opi = $urandom_range(0, 12); s1i = $urandom_range(0, 3); s2i = $urandom_range(0, 4);
        op = (opi < 12) ? (12'h1 << opi) : 12'h0;
        s1 = (s1i < 3) ? (3'h1 << s1i) : 3'h0;
        s2 = (s2i < 4) ? (4'h1 << s2i) : 4'h0;
        en = 1'($urandom_range(0, 1)); wen = 4'($urandom); we = 1'($urandom_range(0, 1));
        wa = 5'($urandom); selres = 1'($urandom_range(0, 1));
        load(mk(pc, inst, op, s1, s2, en, wen, we, wa, selres, r1, r2));
        res = ref_alu(opi, s1i, s2i, pc, inst, r1, r2);
        chk("rand.mem", 160'(e2m), 160'({1'b0, pc, en, wen, selres, we, wa, res, 1'b0, 64'h0}));
        chk("rand.fwd", 160'(e2id), 160'({we & ~selres, wa, res}));
        chk("rand.sram", {stallreq, sen, swen, saddr, swdata}, 160'({1'b0, en, wen, res, r2}));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
